// File: rtl/store_rmw_unit_pkg.sv
// Shared types and constants for the store read-modify-write unit.
// Size encodings, FSM states and lane geometry live here.
package store_rmw_unit_pkg;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'd0,
    SZ_BYTE  = 2'd1,
    SZ_HALF  = 2'd2,
    SZ_UNDEF = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int OFF_BITS = 2;
  localparam int BYTE_W   = 8;
  localparam int HALF_W   = 16;

  // Undefined size, or a halfword that straddles a halfword lane.
  function automatic logic is_bad_req(
    input logic [1:0]          size,
    input logic [OFF_BITS-1:0] off
  );
    return (size == SZ_UNDEF) ||
           ((size == SZ_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/store_rmw_unit_lane_merge.sv
// Combinational lane merge: drops store data into the
// addressed byte/halfword lane of the old memory word.
module store_lane_merge
  import store_rmw_unit_pkg::*;
#(
  parameter int DATA_BITS = 32
) (
  input  logic [DATA_BITS-1:0] old_word,
  input  logic [DATA_BITS-1:0] store_data,
  input  logic [1:0]           size,
  input  logic [OFF_BITS-1:0]  offset,
  output logic [DATA_BITS-1:0] merged
);

  always_comb begin
    merged = old_word;
    unique case (1'b1)
      (size == SZ_BYTE):
        merged[BYTE_W*offset +: BYTE_W] =
          store_data[BYTE_W-1:0];
      (size == SZ_HALF):
        merged[HALF_W*offset[1] +: HALF_W] =
          store_data[HALF_W-1:0];
      (size == SZ_WORD):
        merged = store_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit: word stores write directly, sub-word stores
// read the word, merge the lane and write it back.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  input  logic [1:0]           req_size,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 done,
  output logic                 err
);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [OFF_BITS-1:0]   off_q;
  logic [DATA_BITS-1:0]  data_q;
  logic [1:0]            size_q;
  logic [DATA_BITS-1:0]  wdata_q;
  logic [DATA_BITS-1:0]  merged;
  logic                  accept;

  assign accept = req_valid && (state_q == S_IDLE);

  store_lane_merge #(
    .DATA_BITS (DATA_BITS)
  ) u_merge (
    .old_word   (mem_rdata),
    .store_data (data_q),
    .size       (size_q),
    .offset     (off_q),
    .merged     (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_BITS-1:2], 2'b00};
        off_q   <= req_addr[1:0];
        data_q  <= req_data;
        size_q  <= req_size;
        // word stores write this value unchanged
        wdata_q <= req_data;
      end else if (state_q == S_READ && mem_ack) begin
        wdata_q <= merged;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          unique case (1'b1)
            is_bad_req(req_size, req_addr[1:0]):
              state_d = S_ERR;
            (req_size == SZ_WORD):
              state_d = S_WRITE;
            default:
              state_d = S_READ;
          endcase
        end
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (mem_ack) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_wr = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a small
// handshaking memory responder driven from tasks.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hFFFF_FFFF;
  logic        mem_ack = 1'b0;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;

  store_rmw_unit #(
    .DATA_BITS (32),
    .ADDR_BITS (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_rd && mem_wr) both_hi++;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic run_store(
    input string       tag,
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [31:0] rdata,
    input int          waits,
    input logic [31:0] exp_waddr,
    input logic [31:0] exp_wdata,
    input bit          exp_rd,
    input bit          exp_err
  );
    int cyc = 0;
    int wcnt = 0;
    int rd_acks = 0;
    int wr_acks = 0;
    int strobes = 0;
    int ack_cyc = -1;
    int done_cyc = -1;
    bit got_done = 0;
    bit got_err = 0;
    bit first_rd = 0;
    bit first_wr = 0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    @(negedge clk);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    @(negedge clk);
    req_valid = 1'b0;
    first_rd  = mem_rd;
    first_wr  = mem_wr;
    while (cyc < 40 && !got_done && !got_err) begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      if (mem_rd || mem_wr) strobes++;
      if (mem_rd || mem_wr) begin
        if (wcnt == waits) begin
          mem_ack = 1'b1;
          wcnt    = 0;
          ack_cyc = cyc;
          if (mem_rd) begin
            rd_acks++;
            mem_rdata = rdata;
          end else begin
            wr_acks++;
            waddr = mem_addr;
            wdata = mem_wdata;
          end
        end else begin
          wcnt++;
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
      if (err) got_err = 1;
      @(negedge clk);
      cyc++;
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    if (exp_err) begin
      check({tag, "_err"}, got_err, 1);
      check({tag, "_strobes"}, strobes, 0);
      check({tag, "_ready_after"}, req_ready, 1);
      check({tag, "_err_1cyc"}, err, 0);
    end else begin
      check({tag, "_first_rd"}, first_rd, exp_rd);
      check({tag, "_first_wr"}, first_wr, !exp_rd);
      check({tag, "_rd_acks"}, rd_acks, exp_rd);
      check({tag, "_wr_acks"}, wr_acks, 1);
      check({tag, "_waddr"}, waddr, exp_waddr);
      check({tag, "_wdata"}, wdata, exp_wdata);
      check({tag, "_done"}, got_done, 1);
      check({tag, "_done_lat"}, done_cyc, ack_cyc + 1);
      check({tag, "_no_err"}, got_err, 0);
      check({tag, "_done_1cyc"}, done, 0);
      check({tag, "_ready_after"}, req_ready, 1);
    end
  endtask

  initial begin
    int done_n;
    int wr_n;
    int rd_n;
    int bad;
    logic [31:0] wd1;
    logic [31:0] wd2;

    // reset values, with a request already waiting
    req_valid = 1'b1;
    req_addr  = 32'h0000_0046;
    req_data  = 32'hA5A5_A5A5;
    req_size  = 2'd0;
    #3;
    check("rst_ready", req_ready, 1);
    check("rst_rd", mem_rd, 0);
    check("rst_wr", mem_wr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("first_edge_wr", mem_wr, 1);
    check("first_edge_addr", mem_addr, 32'h0000_0044);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("first_edge_done", done, 1);

    run_store("word", 32'h1000_0006, 32'hDEAD_BEEF, 2'd0,
              32'h0, 1, 32'h1000_0004, 32'hDEAD_BEEF, 0, 0);
    run_store("byte2", 32'h0000_0002, 32'h0000_00AB, 2'd1,
              32'h1122_3344, 0, 32'h0, 32'h11AB_3344, 1, 0);
    run_store("half2", 32'h0000_0002, 32'h0000_CAFE, 2'd2,
              32'h1122_3344, 1, 32'h0, 32'hCAFE_3344, 1, 0);
    run_store("half0", 32'h0000_0000, 32'h0000_CAFE, 2'd2,
              32'h1122_3344, 0, 32'h0, 32'h1122_CAFE, 1, 0);
    run_store("byte3", 32'h0000_0107, 32'h0000_0055, 2'd1,
              32'h1122_3344, 2, 32'h104, 32'h5522_3344, 1, 0);
    run_store("byte0", 32'h0000_0200, 32'hFFFF_FF77, 2'd1,
              32'h1122_3344, 0, 32'h200, 32'h1122_3377, 1, 0);
    run_store("mis_half", 32'h0000_0003, 32'h0000_CAFE, 2'd2,
              32'h0, 0, 32'h0, 32'h0, 0, 1);
    run_store("undef", 32'h0000_0000, 32'h1234_5678, 2'd3,
              32'h0, 0, 32'h0, 32'h0, 0, 1);

    // reset while WRITE waits for an ack
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0020;
    req_data  = 32'h1234_5678;
    req_size  = 2'd0;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_wr_active", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_wr_async_drop", mem_wr, 0);
    check("mid_wr_ready", req_ready, 1);
    bad = 0;
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done || mem_wr || mem_rd) bad++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (done || mem_wr || mem_rd) bad++;
    end
    mem_ack = 1'b0;
    check("mid_wr_quiet", bad, 0);
    run_store("after_rst", 32'h0000_0031, 32'h0000_0099, 2'd1,
              32'hAABB_CCDD, 0, 32'h30, 32'hAABB_99DD, 1, 0);

    // back-to-back, zero-wait, req_valid held
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0080;
    req_data  = 32'h0BAD_F00D;
    req_size  = 2'd0;
    @(negedge clk);
    done_n = 0;
    wr_n   = 0;
    rd_n   = 0;
    wd1    = '0;
    wd2    = '0;
    for (int c = 0; c < 10; c++) begin
      mem_ack   = mem_rd || mem_wr;
      mem_rdata = 32'h1122_3344;
      if (mem_rd) rd_n++;
      if (mem_wr) begin
        wr_n++;
        if (wr_n == 1) wd1 = mem_wdata;
        else wd2 = mem_wdata;
      end
      if (done) done_n++;
      if (c == 0) begin
        req_addr = 32'h0000_0091;
        req_data = 32'h0000_005A;
        req_size = 2'd1;
      end
      if (c == 1) check("b2b_busy_ready", req_ready, 0);
      if (c == 1) check("b2b_done1", done, 1);
      if (c == 2) check("b2b_idle_ready", req_ready, 1);
      if (c == 3) begin
        check("b2b_second_rd", mem_rd, 1);
        check("b2b_second_addr", mem_addr, 32'h90);
        req_valid = 1'b0;
      end
      if (c == 5) check("b2b_done2", done, 1);
      @(negedge clk);
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    check("b2b_done_count", done_n, 2);
    check("b2b_wr_count", wr_n, 2);
    check("b2b_rd_count", rd_n, 1);
    check("b2b_wdata1", wd1, 32'h0BAD_F00D);
    check("b2b_wdata2", wd2, 32'h1122_5A44);

    check("rd_wr_exclusive", both_hi, 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
